// File: rtl/axi_gran_b_merger.sv
// Write-response reassembler: counts per-fragment B responses of split bursts
// and returns one merged B per original burst, in per-ID age order.
module axi_gran_b_merger #(
  parameter int MaxTxns = 8,
  parameter int IdWidth = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IdWidth-1:0] alloc_id_i,
  input  logic [7:0]         alloc_len_i,
  input  logic               alloc_req_i,
  output logic               alloc_gnt_o,
  input  logic [IdWidth-1:0] b_in_id_i,
  input  logic [1:0]         b_in_resp_i,
  input  logic               b_in_valid_i,
  output logic               b_in_ready_o,
  output logic [IdWidth-1:0] b_out_id_o,
  output logic [1:0]         b_out_resp_o,
  output logic               b_out_valid_o,
  input  logic               b_out_ready_i,
  output logic               unexpected_o,
  output logic               busy_o
);

  typedef logic [IdWidth-1:0] id_t;
  localparam int IdxW = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;

  logic [MaxTxns-1:0] r_valid;
  id_t                r_id    [MaxTxns];
  logic [8:0]         r_rem   [MaxTxns];
  logic [1:0]         r_acc   [MaxTxns];
  logic [MaxTxns-1:0] r_allex;
  // r_older[i][j] set: entry i was allocated before entry j
  logic [MaxTxns-1:0][MaxTxns-1:0] r_older;

  logic       r_out_valid;
  id_t        r_out_id;
  logic [1:0] r_out_resp;

  logic [MaxTxns-1:0] w_match;
  logic [MaxTxns-1:0] w_oldest;
  logic [IdxW-1:0]    w_tgt;
  logic [IdxW-1:0]    w_aidx;
  logic               w_hit;
  logic               w_gnt;
  logic               w_final;
  logic               w_ready;
  logic               w_frag_acc;
  logic               w_load;
  logic               w_alloc;
  logic [1:0]         w_acc_nxt;
  logic               w_allex_nxt;
  logic [1:0]         w_merged;

  always_comb begin
    w_match  = '0;
    w_oldest = '0;
    w_tgt    = '0;
    w_aidx   = '0;
    for (int i = 0; i < MaxTxns; i++) begin
      w_match[i] = r_valid[i] & (r_id[i] == b_in_id_i);
    end
    for (int i = 0; i < MaxTxns; i++) begin
      w_oldest[i] = w_match[i];
      for (int j = 0; j < MaxTxns; j++) begin
        if (w_match[j] & r_older[j][i]) w_oldest[i] = 1'b0;
      end
    end
    for (int i = 0; i < MaxTxns; i++) begin
      if (w_oldest[i]) w_tgt = IdxW'(i);
    end
    for (int i = MaxTxns - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_aidx = IdxW'(i);
    end
  end

  assign w_hit      = |w_match;
  assign w_gnt      = ~&r_valid;
  assign w_final    = (r_rem[w_tgt] == 9'd1);
  assign w_ready    = !w_hit | !w_final | !r_out_valid | b_out_ready_i;
  assign w_frag_acc = b_in_valid_i & w_ready & w_hit;
  assign w_load     = w_frag_acc & w_final;
  assign w_alloc    = alloc_req_i & w_gnt;

  // only SLVERR/DECERR feed the accumulator; DECERR wins by magnitude
  assign w_acc_nxt = (b_in_resp_i[1] && (b_in_resp_i > r_acc[w_tgt]))
                   ? b_in_resp_i : r_acc[w_tgt];
  assign w_allex_nxt = r_allex[w_tgt] & (b_in_resp_i == 2'b01);
  assign w_merged    = w_acc_nxt[1] ? w_acc_nxt : {1'b0, w_allex_nxt};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid     <= '0;
      r_older     <= '0;
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
      r_out_resp  <= '0;
    end else begin
      if (w_frag_acc) begin
        if (w_final) begin
          r_valid[w_tgt] <= 1'b0;
        end else begin
          r_rem[w_tgt]   <= r_rem[w_tgt] - 9'd1;
          r_acc[w_tgt]   <= w_acc_nxt;
          r_allex[w_tgt] <= w_allex_nxt;
        end
      end
      if (w_alloc) begin
        r_valid[w_aidx] <= 1'b1;
        r_id[w_aidx]    <= alloc_id_i;
        r_rem[w_aidx]   <= {1'b0, alloc_len_i} + 9'd1;
        r_acc[w_aidx]   <= 2'b00;
        r_allex[w_aidx] <= 1'b1;
        for (int j = 0; j < MaxTxns; j++) begin
          r_older[w_aidx][j] <= 1'b0;
          r_older[j][w_aidx] <= r_valid[j];
        end
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_id    <= r_id[w_tgt];
        r_out_resp  <= w_merged;
      end else if (b_out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign alloc_gnt_o   = w_gnt;
  assign b_in_ready_o  = w_ready;
  assign b_out_valid_o = r_out_valid;
  assign b_out_id_o    = r_out_id;
  assign b_out_resp_o  = r_out_resp;
  assign unexpected_o  = b_in_valid_i & !w_hit;
  assign busy_o        = (|r_valid) | r_out_valid;

endmodule

// File: tb/tb_axi_gran_b_merger.sv
// Bench for axi_gran_b_merger: directed scenarios plus random traffic
// checked every cycle against an in-order list model of outstanding bursts.
module tb_axi_gran_b_merger;

  localparam int MAXT = 8;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] alloc_id_i = '0;
  logic [7:0] alloc_len_i = '0;
  logic       alloc_req_i = 1'b0;
  logic       alloc_gnt_o;
  logic [3:0] b_in_id_i = '0;
  logic [1:0] b_in_resp_i = '0;
  logic       b_in_valid_i = 1'b0;
  logic       b_in_ready_o;
  logic [3:0] b_out_id_o;
  logic [1:0] b_out_resp_o;
  logic       b_out_valid_o;
  logic       b_out_ready_i = 1'b0;
  logic       unexpected_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_gran_b_merger #(.MaxTxns(MAXT), .IdWidth(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .alloc_id_i(alloc_id_i), .alloc_len_i(alloc_len_i),
    .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o),
    .b_in_id_i(b_in_id_i), .b_in_resp_i(b_in_resp_i),
    .b_in_valid_i(b_in_valid_i), .b_in_ready_o(b_in_ready_o),
    .b_out_id_o(b_out_id_o), .b_out_resp_o(b_out_resp_o),
    .b_out_valid_o(b_out_valid_o), .b_out_ready_i(b_out_ready_i),
    .unexpected_o(unexpected_o), .busy_o(busy_o)
  );

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Model: outstanding bursts in allocation order; first ID match is oldest
  typedef struct {
    logic [3:0] id;
    int         rem;
    logic [1:0] err;
    bit         allex;
  } ent_t;

  ent_t       q[$];
  bit         m_ov = 1'b0;
  logic [3:0] m_id = '0;
  logic [1:0] m_resp = '0;

  always @(negedge clk) begin
    int  k;
    bit  hit, fin, rdy, gnt;
    ent_t e;
    if (rst_i) begin
      q.delete();
      m_ov = 1'b0;
    end else begin
      k = -1;
      foreach (q[i]) if (k < 0 && q[i].id == b_in_id_i) k = i;
      hit = (k >= 0);
      fin = hit && (q[k].rem == 1);
      gnt = (q.size() < MAXT);
      rdy = !hit || !fin || !m_ov || b_out_ready_i;
      chk("m_gnt", alloc_gnt_o, gnt);
      chk("m_ready", b_in_ready_o, rdy);
      chk("m_unexp", unexpected_o, b_in_valid_i && !hit);
      chk("m_bvalid", b_out_valid_o, m_ov);
      chk("m_busy", busy_o, (q.size() > 0) || m_ov);
      if (m_ov) begin
        chk("m_bid", b_out_id_o, m_id);
        chk("m_bresp", b_out_resp_o, m_resp);
      end
      if (m_ov && b_out_ready_i) m_ov = 1'b0;
      if (b_in_valid_i && rdy && hit) begin
        if (b_in_resp_i >= 2 && b_in_resp_i > q[k].err) q[k].err = b_in_resp_i;
        if (b_in_resp_i != 2'd1) q[k].allex = 1'b0;
        q[k].rem--;
        if (fin) begin
          m_ov   = 1'b1;
          m_id   = q[k].id;
          m_resp = (q[k].err != 0) ? q[k].err : (q[k].allex ? 2'd1 : 2'd0);
          q.delete(k);
        end
      end
      if (alloc_req_i && gnt) begin
        e.id = alloc_id_i;
        e.rem = int'(alloc_len_i) + 1;
        e.err = 2'd0;
        e.allex = 1'b1;
        q.push_back(e);
      end
    end
  end

  task automatic alloc(input logic [3:0] id, input logic [7:0] len);
    int n;
    alloc_req_i = 1'b1;
    alloc_id_i  = id;
    alloc_len_i = len;
    n = 0;
    forever begin
      @(negedge clk);
      if (alloc_gnt_o) break;
      n++;
      if (n >= 50) begin
        chk("alloc_timeout", alloc_gnt_o, 1);
        break;
      end
    end
    @(posedge clk); #1;
    alloc_req_i = 1'b0;
  endtask

  task automatic frag(input logic [3:0] id, input logic [1:0] r);
    int n;
    b_in_valid_i = 1'b1;
    b_in_id_i    = id;
    b_in_resp_i  = r;
    n = 0;
    forever begin
      @(negedge clk);
      if (b_in_ready_o) break;
      n++;
      if (n >= 50) begin
        chk("frag_timeout", b_in_ready_o, 1);
        break;
      end
    end
    @(posedge clk); #1;
    b_in_valid_i = 1'b0;
  endtask

  task automatic take_b(input logic [3:0] id, input logic [1:0] r,
                        input string n);
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      if (b_out_valid_o) break;
      c++;
      if (c >= 50) break;
    end
    chk({n, "_valid"}, b_out_valid_o, 1);
    chk({n, "_id"}, b_out_id_o, id);
    chk({n, "_resp"}, b_out_resp_o, r);
    b_out_ready_i = 1'b1;
    @(posedge clk); #1;
    b_out_ready_i = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    chk("rst_gnt", alloc_gnt_o, 1);
    chk("rst_ready", b_in_ready_o, 1);
    chk("rst_bvalid", b_out_valid_o, 0);
    chk("rst_bid", b_out_id_o, 0);
    chk("rst_bresp", b_out_resp_o, 0);
    chk("rst_busy", busy_o, 0);

    // single burst: 4 fragments, B exactly one cycle after the last
    alloc(4'd3, 8'd3);
    for (int i = 0; i < 3; i++) begin
      frag(4'd3, 2'd0);
      chk("sb_early", b_out_valid_o, 0);
    end
    frag(4'd3, 2'd0);
    chk("sb_lat1", b_out_valid_o, 1);
    take_b(4'd3, 2'd0, "sb");

    // resp merging
    alloc(4'd1, 8'd2);
    frag(4'd1, 2'd0); frag(4'd1, 2'd2); frag(4'd1, 2'd0);
    take_b(4'd1, 2'd2, "mg_slverr");
    alloc(4'd1, 8'd2);
    repeat (3) frag(4'd1, 2'd1);
    take_b(4'd1, 2'd1, "mg_exokay");
    alloc(4'd1, 8'd2);
    frag(4'd1, 2'd1); frag(4'd1, 2'd3); frag(4'd1, 2'd1);
    take_b(4'd1, 2'd3, "mg_decerr");

    // per-ID ordering, distinguished by resp
    alloc(4'd2, 8'd0);
    alloc(4'd2, 8'd1);
    frag(4'd2, 2'd1);
    take_b(4'd2, 2'd1, "ord_first");
    frag(4'd2, 2'd0); frag(4'd2, 2'd2);
    take_b(4'd2, 2'd2, "ord_second");

    // full table and output back-pressure
    for (int i = 8; i < 16; i++) alloc(4'(i), 8'd1);
    chk("full_gnt", alloc_gnt_o, 0);
    frag(4'd8, 2'd0); frag(4'd8, 2'd0);
    frag(4'd9, 2'd2);
    b_in_valid_i = 1'b1; b_in_id_i = 4'd9; b_in_resp_i = 2'd0;
    #1 chk("stall_ready", b_in_ready_o, 0);
    chk("stall_bvalid", b_out_valid_o, 1);
    @(posedge clk); #1;
    chk("stall_hold", b_in_ready_o, 0);
    b_in_id_i = 4'd10;
    #1 chk("nonfinal_ok", b_in_ready_o, 1);
    @(posedge clk); #1;
    b_in_valid_i = 1'b0;
    take_b(4'd8, 2'd0, "full_b8");
    frag(4'd9, 2'd0);
    take_b(4'd9, 2'd2, "full_b9");
    frag(4'd10, 2'd1);
    take_b(4'd10, 2'd0, "full_b10");
    for (int i = 11; i < 16; i++) begin
      frag(4'(i), 2'd1); frag(4'(i), 2'd1);
      take_b(4'(i), 2'd1, "full_drain");
    end
    chk("drain_busy", busy_o, 0);

    // unexpected fragment
    b_in_valid_i = 1'b1; b_in_id_i = 4'd7; b_in_resp_i = 2'd0;
    #1 chk("unx_ready", b_in_ready_o, 1);
    chk("unx_pulse", unexpected_o, 1);
    @(posedge clk); #1;
    b_in_valid_i = 1'b0;
    #1 chk("unx_clear", unexpected_o, 0);
    chk("unx_nob", b_out_valid_o, 0);
    chk("unx_busy", busy_o, 0);

    // reset mid-operation
    alloc(4'd4, 8'd3); alloc(4'd5, 8'd3);
    frag(4'd4, 2'd2); frag(4'd5, 2'd0);
    chk("mid_busy", busy_o, 1);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("mr_gnt", alloc_gnt_o, 1);
    chk("mr_ready", b_in_ready_o, 1);
    chk("mr_bvalid", b_out_valid_o, 0);
    chk("mr_bid", b_out_id_o, 0);
    chk("mr_bresp", b_out_resp_o, 0);
    chk("mr_busy", busy_o, 0);
    repeat (6) begin
      frag(4'd4, 2'd0);
      chk("mr_nob", b_out_valid_o, 0);
    end

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      alloc_req_i   = ($urandom_range(0, 9) < 3);
      alloc_id_i    = 4'($urandom_range(0, 3));
      alloc_len_i   = 8'($urandom_range(0, 3));
      b_in_valid_i  = ($urandom_range(0, 9) < 6);
      b_in_id_i     = 4'($urandom_range(0, 4));
      b_in_resp_i   = 2'($urandom_range(0, 3));
      b_out_ready_i = ($urandom_range(0, 9) < 7);
      rst_i         = ($urandom_range(0, 999) == 0);
      @(posedge clk); #1;
    end
    alloc_req_i = 1'b0; b_in_valid_i = 1'b0;
    b_out_ready_i = 1'b1; rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
